// File: rtl/shift_accumulate_if.sv
// shift_accumulate_if: groups one CORDIC micro-rotation stage's datapath signals.
//   x, y   : current coordinates, signed two's complement, WIDTH bits
//   z      : residual angle, signed, 1024 units per radian
//   i      : iteration index / shift amount 0..31, static per instance
//   tan    : arctan(2^-i) in z units, unsigned
//   x_out, y_out, z_out : registered stage results
// Modports: master drives x/y/z/i/tan and observes the outputs; slave is the stage.
interface shift_accumulate_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic [4:0]       i;
  logic [WIDTH-1:0] tan;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic [WIDTH-1:0] z_out;

  modport master (
    output x, y, z, i, tan,
    input  x_out, y_out, z_out
  );

  modport slave (
    input  x, y, z, i, tan,
    output x_out, y_out, z_out
  );
endinterface

// File: rtl/shift_accumulate.sv
// shift_accumulate: one rotation-mode CORDIC micro-rotation, one-cycle latency,
// accepts a new sample every cycle. Stages chain directly (x_out -> x of the next).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears all outputs, wins over the update
//   bus   : shift_accumulate_if.slave carrying x/y/z/i/tan in and x_out/y_out/z_out out
module shift_accumulate #(
  parameter int unsigned WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  shift_accumulate_if.slave   bus
);

  logic                    w_rot_pos;
  logic signed [WIDTH-1:0] w_x_shift;
  logic signed [WIDTH-1:0] w_y_shift;
  logic [WIDTH-1:0]        w_x_next;
  logic [WIDTH-1:0]        w_y_next;
  logic [WIDTH-1:0]        w_z_next;

  logic [WIDTH-1:0]        r_x_out;
  logic [WIDTH-1:0]        r_y_out;
  logic [WIDTH-1:0]        r_z_out;

  // z = 0 rotates in the positive direction.
  assign w_rot_pos = ~bus.z[WIDTH-1];

  // Arithmetic shifts of the pre-update coordinates; bits shifted out are dropped.
  assign w_x_shift = $signed(bus.x) >>> bus.i;
  assign w_y_shift = $signed(bus.y) >>> bus.i;

  // All arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    w_x_next = bus.x;
    w_y_next = bus.y;
    w_z_next = bus.z;
    if (w_rot_pos) begin
      w_x_next = bus.x - w_y_shift;
      w_y_next = bus.y + w_x_shift;
      w_z_next = bus.z - bus.tan;
    end else begin
      w_x_next = bus.x + w_y_shift;
      w_y_next = bus.y - w_x_shift;
      w_z_next = bus.z + bus.tan;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_out <= '0;
      r_y_out <= '0;
      r_z_out <= '0;
    end else begin
      r_x_out <= w_x_next;
      r_y_out <= w_y_next;
      r_z_out <= w_z_next;
    end
  end

  assign bus.x_out = r_x_out;
  assign bus.y_out = r_y_out;
  assign bus.z_out = r_z_out;

endmodule

// File: tb/tb_shift_accumulate.sv
// Testbench for shift_accumulate: directed vectors with hand-computed results.
// The driver pushes each expected result into a queue as it applies a vector;
// an independent monitor pops and compares one cycle later.
module tb_shift_accumulate;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } exp_t;

  logic clk;
  logic rst_n;
  logic issued;
  logic drive_done;
  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  shift_accumulate_if #(.WIDTH(WIDTH)) bus ();

  shift_accumulate #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one vector just after a falling edge and records its expected result.
  task automatic drive(input string name, input logic rst, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z,
                       input logic [4:0] sh, input logic [WIDTH-1:0] tan,
                       input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] ey,
                       input logic [WIDTH-1:0] ez);
    exp_t e;
    rst_n  = rst;
    bus.x  = x;
    bus.y  = y;
    bus.z  = z;
    bus.i  = sh;
    bus.tan = tan;
    e.name = name;
    e.x    = ex;
    e.y    = ey;
    e.z    = ez;
    exp_q.push_back(e);
    issued = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: a vector issued before a rising edge is checked 1 time unit after it.
  initial begin
    logic v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = issued;
      #1;
      if (v) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s: output presented with no expected entry", "scoreboard");
        end else begin
          e = exp_q.pop_front();
          if (bus.x_out !== e.x || bus.y_out !== e.y || bus.z_out !== e.z) begin
            n_fail++;
            $display("FAIL %s: got x=%h y=%h z=%h, want x=%h y=%h z=%h", e.name,
                     bus.x_out, bus.y_out, bus.z_out, e.x, e.y, e.z);
          end
        end
      end
    end
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    issued     = 1'b0;
    drive_done = 1'b0;
    rst_n      = 1'b0;
    bus.x      = '0;
    bus.y      = '0;
    bus.z      = '0;
    bus.i      = '0;
    bus.tan    = '0;
    @(negedge clk);

    drive("reset",      1'b0, 5, 6, 7, 5'd0, 0, 0, 0, 0);
    drive("pos_angle",  1'b1, 1024, 0, 804, 5'd0, 804, 1024, 1024, 0);
    drive("neg_angle",  1'b1, 1024, 0, -100, 5'd1, 474, 1024, -512, 374);
    drive("arith_shr",  1'b1, -7, -3, 0, 5'd1, 474, -5, -7, -474);
    drive("shr31_neg",  1'b1, -5, 0, 0, 5'd31, 0, -5, -1, 0);
    drive("shr31_pos",  1'b1, 3, -5, -1, 5'd31, 2, 2, -5, 1);
    drive("wrap",       1'b1, 32'h7FFF_FFFF, -1, 5, 5'd0, 1,
          32'h8000_0000, 32'h7FFF_FFFE, 4);
    // Back-to-back stream with a one-cycle reset pulse in the middle.
    drive("stream_a",   1'b1, 100, 200, -1, 5'd2, 10, 150, 175, 9);
    drive("stream_b",   1'b1, -1000, 300, 50, 5'd3, 125, -1037, 175, -75);
    drive("mid_reset",  1'b0, 1234, -567, 89, 5'd2, 300, 0, 0, 0);
    drive("stream_c",   1'b1, 0, -64, -804, 5'd4, 63, -4, -64, -741);
    drive("stream_d",   1'b1, 1024, 0, 804, 5'd0, 804, 1024, 1024, 0);

    issued = 1'b0;
    repeat (3) @(negedge clk);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d entries left, want 0", "drain", exp_q.size());
    end
    drive_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #100000;
    if (!drive_done) begin
      $display("FAIL %s: time limit reached", "timeout");
      $fatal(1, "timeout");
    end
  end

endmodule
